// File: rtl/wagu_part_sched.sv
// Per-layer weight part sequencer: loads each weight part, kicks the AGUs, counts group_end
// pulses until the part completes, and reports done / watchdog error to top-level control.
module wagu_part_sched #(
    parameter logic [3:0]  MODE_CONV = 4'd1,
    parameter logic [3:0]  MODE_FC   = 4'd2,
    parameter logic [3:0]  MODE_ADD  = 4'd3,
    parameter logic [3:0]  MODE_DW   = 4'd4,
    parameter logic [19:0] TIMEOUT   = 20'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_layer_start,
    input  logic [3:0] i_mode,
    input  logic [4:0] i_part_num,
    input  logic [7:0] i_out_piece,
    input  logic       i_wload_done,
    input  logic       i_group_end,
    input  logic       i_add_done,
    output logic       o_wload_req,
    output logic [4:0] o_part_idx,
    output logic       o_start_calculate,
    output logic       o_add_start,
    output logic       o_busy,
    output logic       o_layer_done,
    output logic       o_error
);

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StStart,
        StRun,
        StNext,
        StDone
    } state_t;

    state_t      state_q;
    logic [3:0]  mode_q;
    logic [4:0]  parts_q;
    logic [7:0]  groups_q;
    logic [7:0]  grp_cnt_q;
    logic [19:0] wdog_q;

    logic mode_ok;
    logic is_add;
    logic run_event;

    assign mode_ok = (i_mode == MODE_CONV) || (i_mode == MODE_FC) ||
                     (i_mode == MODE_ADD)  || (i_mode == MODE_DW);
    assign is_add  = (mode_q == MODE_ADD);
    // ADD progresses on add_done only; group pulses are meaningless there.
    assign run_event = is_add ? i_add_done : i_group_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= StIdle;
            mode_q            <= 4'd0;
            parts_q           <= 5'd1;
            groups_q          <= 8'd1;
            grp_cnt_q         <= 8'd0;
            wdog_q            <= 20'd0;
            o_wload_req       <= 1'b0;
            o_part_idx        <= 5'd0;
            o_start_calculate <= 1'b0;
            o_add_start       <= 1'b0;
            o_busy            <= 1'b0;
            o_layer_done      <= 1'b0;
            o_error           <= 1'b0;
        end else begin
            o_start_calculate <= 1'b0;
            o_add_start       <= 1'b0;
            o_layer_done      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_layer_start) begin
                        mode_q   <= i_mode;
                        parts_q  <= (i_mode == MODE_ADD || i_part_num == 5'd0) ? 5'd1
                                                                              : i_part_num;
                        groups_q <= (i_out_piece == 8'd0) ? 8'd1 : i_out_piece;
                        if (mode_ok) begin
                            o_error     <= 1'b0;
                            o_part_idx  <= 5'd0;
                            o_wload_req <= 1'b1;
                            o_busy      <= 1'b1;
                            state_q     <= StWload;
                        end else begin
                            o_error <= 1'b1;
                        end
                    end
                end
                StWload: begin
                    if (i_wload_done) begin
                        o_wload_req <= 1'b0;
                        // Start pulse is registered so it is high exactly while in StStart.
                        if (is_add) o_add_start       <= 1'b1;
                        else        o_start_calculate <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    grp_cnt_q <= 8'd0;
                    wdog_q    <= 20'd0;
                    state_q   <= StRun;
                end
                StRun: begin
                    if (run_event) begin
                        wdog_q    <= 20'd0;
                        grp_cnt_q <= grp_cnt_q + 8'd1;
                        if (is_add || (grp_cnt_q + 8'd1) == groups_q) state_q <= StNext;
                    end else if (wdog_q == TIMEOUT - 20'd1) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + 20'd1;
                    end
                end
                StNext: begin
                    if (o_part_idx == parts_q - 5'd1) begin
                        o_layer_done <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        o_part_idx  <= o_part_idx + 5'd1;
                        o_wload_req <= 1'b1;
                        state_q     <= StWload;
                    end
                end
                StDone: begin
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wagu_part_sched.sv
// Bench for wagu_part_sched: a reactive DMA/AGU environment drives each layer while a
// part-level model predicts request, start, group and done counts and their timing.
module tb_wagu_part_sched;

    localparam logic [19:0] TIMEOUT = 20'd50;
    localparam logic [3:0]  M_CONV  = 4'd1;
    localparam logic [3:0]  M_FC    = 4'd2;
    localparam logic [3:0]  M_ADD   = 4'd3;
    localparam logic [3:0]  M_DW    = 4'd4;
    localparam int          LIMIT   = 3000;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_layer_start;
    logic [3:0] i_mode;
    logic [4:0] i_part_num;
    logic [7:0] i_out_piece;
    logic       i_wload_done;
    logic       i_group_end;
    logic       i_add_done;
    logic       o_wload_req;
    logic [4:0] o_part_idx;
    logic       o_start_calculate;
    logic       o_add_start;
    logic       o_busy;
    logic       o_layer_done;
    logic       o_error;

    always #5 clk = ~clk;

    wagu_part_sched #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_layer_start    (i_layer_start),
        .i_mode           (i_mode),
        .i_part_num       (i_part_num),
        .i_out_piece      (i_out_piece),
        .i_wload_done     (i_wload_done),
        .i_group_end      (i_group_end),
        .i_add_done       (i_add_done),
        .o_wload_req      (o_wload_req),
        .o_part_idx       (o_part_idx),
        .o_start_calculate(o_start_calculate),
        .o_add_start      (o_add_start),
        .o_busy           (o_busy),
        .o_layer_done     (o_layer_done),
        .o_error          (o_error)
    );

    int checks   = 0;
    int failures = 0;
    int t;
    int n_req, n_sc, n_as, n_ge, n_done, n_overlap, lat_bad;
    int t_done, t_last, t_err, t_start, budget_used;
    int idx_q[$];
    logic [3:0] modes [4] = '{M_CONV, M_FC, M_ADD, M_DW};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic clear_pulses;
        i_layer_start = 1'b0;
        i_wload_done  = 1'b0;
        i_group_end   = 1'b0;
        i_add_done    = 1'b0;
    endtask

    function automatic logic [10:0] all_outs;
        return {o_wload_req, o_part_idx, o_start_calculate, o_add_start, o_busy,
                o_layer_done, o_error};
    endfunction

    // Plays DMA / AGU / ADD engine around one layer. ge_gap or add_lat of 0 means "never".
    // abort_part >= 0 returns one cycle into RUN of that part.
    task automatic run_layer(input logic [3:0] mode, input logic [4:0] pn, input logic [7:0] op,
                             input int wl_lat, input int ge_gap, input int add_lat,
                             input bit noise, input int abort_part);
        bit wl_pend  = 0;
        bit wl_sent  = 0;
        bit armed    = 0;
        bit add_pend = 0;
        int t_req = 0, t_arm = 0, t_add = 0, t_wd = -100;
        int b;
        n_req = 0; n_sc = 0; n_as = 0; n_ge = 0; n_done = 0; n_overlap = 0; lat_bad = 0;
        t_done = -1; t_last = -1; t_err = -1; t_start = -1;
        idx_q.delete();
        clear_pulses();
        i_layer_start = 1'b1;
        i_mode        = mode;
        i_part_num    = pn;
        i_out_piece   = op;
        t = 0;
        step();
        for (b = 0; b < LIMIT; b++) begin
            clear_pulses();
            if (o_start_calculate && o_add_start) n_overlap++;
            if (!o_wload_req) begin
                wl_pend = 0;
            end else if (!wl_pend) begin
                wl_pend = 1; wl_sent = 0; t_req = t; armed = 0;
                n_req++;
                idx_q.push_back(int'(o_part_idx));
            end
            if (o_start_calculate) begin
                n_sc++;
                t_start = t;
                if (t != t_wd + 1) lat_bad++;
                armed = (ge_gap > 0);
                t_arm = t;
                if (abort_part == int'(o_part_idx)) begin
                    step();
                    return;
                end
            end
            if (o_add_start) begin
                n_as++;
                t_start = t;
                if (t != t_wd + 1) lat_bad++;
                add_pend = (add_lat > 0);
                t_add = t;
            end
            if (o_layer_done) begin
                n_done++;
                t_done = t;
                break;
            end
            if (o_error) begin
                t_err = t;
                break;
            end
            if (wl_pend && !wl_sent && (t - t_req) == wl_lat) begin
                i_wload_done = 1'b1; wl_sent = 1; t_wd = t;
            end
            if (armed && t > t_arm && ((t - t_arm) % ge_gap) == 0) begin
                i_group_end = 1'b1; n_ge++; t_last = t;
            end else if (noise && !armed && $urandom_range(0, 3) == 0) begin
                i_group_end = 1'b1;
            end
            if (add_pend && (t - t_add) == add_lat) begin
                i_add_done = 1'b1; add_pend = 0; t_last = t;
            end
            if (noise && o_busy && $urandom_range(0, 5) == 0) begin
                i_layer_start = 1'b1;
                i_mode        = 4'($urandom_range(0, 15));
                i_part_num    = 5'd7;
                i_out_piece   = 8'($urandom_range(0, 255));
            end
            step();
        end
        budget_used = b;
        clear_pulses();
        check("bounded_wait", 32'(b < LIMIT), 1);
    endtask

    // Model: parts/groups come straight from the layer rules, independent of sequencing.
    task automatic check_layer(input string tag, input logic [3:0] mode, input logic [4:0] pn,
                               input logic [7:0] op);
        bit is_add = (mode == M_ADD);
        int parts  = is_add ? 1 : (pn == 0 ? 1 : int'(pn));
        int groups = (op == 0) ? 1 : int'(op);
        bit seq_ok = (idx_q.size() == parts);
        foreach (idx_q[i]) if (idx_q[i] != i) seq_ok = 0;
        check({tag, ".req_count"}, n_req, parts);
        check({tag, ".start_calc_count"}, n_sc, is_add ? 0 : parts);
        check({tag, ".add_start_count"}, n_as, is_add ? 1 : 0);
        check({tag, ".groups_consumed"}, n_ge, is_add ? 0 : parts * groups);
        check({tag, ".done_count"}, n_done, 1);
        check({tag, ".done_latency"}, t_done - t_last, 2);
        check({tag, ".start_latency_bad"}, lat_bad, 0);
        check({tag, ".start_overlap"}, n_overlap, 0);
        check({tag, ".part_idx_seq"}, 32'(seq_ok), 1);
        check({tag, ".part_idx_at_done"}, o_part_idx, parts - 1);
        check({tag, ".error_clear"}, o_error, 0);
        step();
        check({tag, ".busy_after_done"}, o_busy, 0);
        check({tag, ".done_one_cycle"}, o_layer_done, 0);
        check({tag, ".part_idx_held"}, o_part_idx, parts - 1);
    endtask

    initial begin
        logic [3:0] m;
        logic [4:0] pn;
        logic [7:0] op;
        rst = 1'b1;
        clear_pulses();
        i_mode = 4'd0; i_part_num = 5'd0; i_out_piece = 8'd0;
        t = 0;
        step();
        step();
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        step();
        check("idle_after_reset", all_outs(), 0);

        run_layer(M_CONV, 5'd3, 8'd4, 5, 10, 0, 0, -1);
        check_layer("conv_3x4", M_CONV, 5'd3, 8'd4);

        run_layer(M_ADD, 5'd5, 8'd2, 3, 0, 6, 0, -1);
        check_layer("add_5", M_ADD, 5'd5, 8'd2);

        run_layer(M_FC, 5'd0, 8'd0, 2, 4, 0, 0, -1);
        check_layer("fc_zero", M_FC, 5'd0, 8'd0);

        run_layer(M_CONV, 5'd2, 8'd3, 3, 5, 0, 1, -1);
        check_layer("restart_ignored", M_CONV, 5'd2, 8'd3);

        // No group_end at all: watchdog must fire TIMEOUT cycles into RUN.
        run_layer(M_CONV, 5'd1, 8'd1, 3, 0, 0, 0, -1);
        check("wdog_cycle", t_err - t_start, int'(TIMEOUT) + 1);
        check("wdog_error", o_error, 1);
        check("wdog_busy", o_busy, 0);
        check("wdog_no_done", n_done, 0);
        step();
        check("wdog_error_sticky", o_error, 1);

        run_layer(M_DW, 5'd2, 8'd2, 1, 3, 0, 0, -1);
        check_layer("dw_after_wdog", M_DW, 5'd2, 8'd2);

        // Asynchronous reset during RUN of part 1.
        run_layer(M_CONV, 5'd3, 8'd2, 2, 4, 0, 0, 1);
        check("pre_abort_part_idx", o_part_idx, 1);
        check("pre_abort_busy", o_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check("no_done_after_abort", all_outs(), 0);
        run_layer(M_CONV, 5'd2, 8'd2, 2, 4, 0, 0, -1);
        check_layer("after_abort", M_CONV, 5'd2, 8'd2);

        clear_pulses();
        i_layer_start = 1'b1;
        i_mode        = 4'd9;
        i_part_num    = 5'd2;
        i_out_piece   = 8'd2;
        step();
        clear_pulses();
        check("illegal_error", o_error, 1);
        check("illegal_busy", o_busy, 0);
        check("illegal_no_req", o_wload_req, 0);
        step();
        step();
        check("illegal_stays_idle", o_busy, 0);

        for (int k = 0; k < 8; k++) begin
            m  = modes[$urandom_range(0, 3)];
            pn = 5'($urandom_range(0, 4));
            op = 8'($urandom_range(0, 4));
            run_layer(m, pn, op, $urandom_range(1, 6), $urandom_range(2, 8),
                      $urandom_range(1, 8), 1, -1);
            check_layer($sformatf("rand%0d", k), m, pn, op);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
